// File: rtl/regfile_hc_param.sv
// regfile_hc_param: parametrised hot/cold integer register file.
// Registers 0..HOT_REGS-1 are always accessible (hot). The rest (cold) need
// cold_en_i=1 to be read or written. Reads are combinational and writes are
// committed on the rising clk edge. Any cold access made without
// authorisation is recorded in a registered error log: a sticky flag, a
// saturating count and the first offending address.
// x0 reads as zero and ignores writes in normal mode. It behaves as a real
// register only while is_16_i=1.
// Optional feature: define RF_BYPASS_EN to forward an accepted write to any
// read port addressing the same register in the same cycle.
module regfile_hc_param #(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter int HOT_REGS  = 16,
    parameter int NUM_RD    = 2,
    parameter int ERR_CNT_W = 8,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD*AW-1:0]   raddr_i,
    output logic [NUM_RD*XLEN-1:0] rdata_o,
    input  logic [AW-1:0]          waddr_i,
    input  logic [XLEN-1:0]        wdata,
    input  logic                   regwrite,
    input  logic                   is_16_i,
    input  logic                   cold_en_i,
    input  logic                   err_clr_i,
    output logic                   cold_en_err,
    output logic [ERR_CNT_W-1:0]   err_cnt_o,
    output logic [AW-1:0]          err_addr_o
);

    localparam logic [AW-1:0]        HOT_A   = AW'(HOT_REGS);
    localparam logic [AW-1:0]        ZERO_A  = {AW{1'b0}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    // An address is cold when it lies at or above the hot/cold boundary.
    function automatic logic is_cold(input logic [AW-1:0] a);
        return (a >= HOT_A);
    endfunction

    logic [XLEN-1:0]        r_regs [NREGS];
    logic                   r_err_flag;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [AW-1:0]          r_err_addr;

    logic                   w_wr_cold;
    logic                   w_wr_ok;
    logic                   w_wr_viol;
    logic [NUM_RD-1:0]      w_rd_viol;
    logic                   w_any_viol;
    logic [AW-1:0]          w_viol_addr;
    logic [NUM_RD*XLEN-1:0] w_rdata;

    // A write is accepted only if it avoids normal-mode x0 and respects the
    // cold authorisation. An unauthorised cold write is a violation.
    assign w_wr_cold  = is_cold(waddr_i);
    assign w_wr_ok    = regwrite
                        && !((waddr_i == ZERO_A) && !is_16_i)
                        && (!w_wr_cold || cold_en_i);
    assign w_wr_viol  = regwrite && w_wr_cold && !cold_en_i;
    assign w_any_viol = w_wr_viol || (|w_rd_viol);

    // Per-port read violations and the prioritised violation address.
    // The loop scans from the highest port down and the write is applied
    // last, so the final winner is the write port, then port 0, 1, ...
    always_comb begin
        w_rd_viol   = {NUM_RD{1'b0}};
        w_viol_addr = ZERO_A;
        for (int k = NUM_RD - 1; k >= 0; k--) begin
            w_rd_viol[k] = is_cold(raddr_i[k*AW +: AW]) && !cold_en_i;
            w_viol_addr  = w_rd_viol[k] ? raddr_i[k*AW +: AW] : w_viol_addr;
        end
        w_viol_addr = w_wr_viol ? waddr_i : w_viol_addr;
    end

    // Combinational read ports with x0 and cold-bank masking.
    always_comb begin
        w_rdata = {(NUM_RD*XLEN){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if ((raddr_i[k*AW +: AW] == ZERO_A) && !is_16_i) begin
                w_rdata[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (is_cold(raddr_i[k*AW +: AW]) && !cold_en_i) begin
                w_rdata[k*XLEN +: XLEN] = {XLEN{1'b0}};
`ifdef RF_BYPASS_EN
            end else if (w_wr_ok && (raddr_i[k*AW +: AW] == waddr_i)) begin
                w_rdata[k*XLEN +: XLEN] = wdata;
`endif
            end else begin
                w_rdata[k*XLEN +: XLEN] = r_regs[raddr_i[k*AW +: AW]];
            end
        end
    end

    assign rdata_o = w_rdata;

    // Register storage. Reset clears every register, x0 included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_regs[waddr_i] <= wdata;
        end
    end

    // Error log. A violation in a cycle overrides a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= {ERR_CNT_W{1'b0}};
            r_err_addr <= ZERO_A;
        end else if (w_any_viol) begin
            r_err_flag <= 1'b1;
            if (err_clr_i) begin
                r_err_cnt <= CNT_ONE;
            end else if (r_err_cnt == CNT_MAX) begin
                r_err_cnt <= CNT_MAX;
            end else begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
            if (err_clr_i || !r_err_flag) begin
                r_err_addr <= w_viol_addr;
            end
        end else if (err_clr_i) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= {ERR_CNT_W{1'b0}};
            r_err_addr <= ZERO_A;
        end
    end

    assign cold_en_err = r_err_flag;
    assign err_cnt_o   = r_err_cnt;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_regfile_hc_param.sv
// Self-checking bench for regfile_hc_param (4 read ports, other parameters at
// their defaults). Directed steps follow the intended behaviour. A random
// phase follows, checked against an array/queue reference model.
module tb_regfile_hc_param;

    localparam int XLEN = 64;
    localparam int NREGS = 32;
    localparam int HOT = 16;
    localparam int NRD = 4;
    localparam int CW = 8;
    localparam int AW = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NRD*AW-1:0]     raddr;
    logic [NRD*XLEN-1:0]   rdata;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic                  regwrite;
    logic                  is16;
    logic                  cold_en;
    logic                  clr;
    logic                  err_flag;
    logic [CW-1:0]         err_cnt;
    logic [AW-1:0]         err_addr;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [63:0] mem [NREGS];
    bit          m_flag;
    int          m_cnt;
    int          m_addr;

    regfile_hc_param #(
        .XLEN(XLEN), .NREGS(NREGS), .HOT_REGS(HOT), .NUM_RD(NRD), .ERR_CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata),
        .waddr_i(waddr), .wdata(wdata), .regwrite(regwrite), .is_16_i(is16),
        .cold_en_i(cold_en), .err_clr_i(clr), .cold_en_err(err_flag),
        .err_cnt_o(err_cnt), .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit wr_accepted();
        if (!regwrite) return 1'b0;
        if (int'(waddr) == 0 && !is16) return 1'b0;
        if (int'(waddr) >= HOT && !cold_en) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] model_rd(input int a);
        if (a == 0 && !is16) return 64'd0;
        if (a >= HOT && !cold_en) return 64'd0;
`ifdef RF_BYPASS_EN
        if (wr_accepted() && a == int'(waddr)) return wdata;
`endif
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mem[i] = 64'd0;
        m_flag = 1'b0;
        m_cnt  = 0;
        m_addr = 0;
    endtask

    task automatic model_check(input string tag);
        for (int k = 0; k < NRD; k++)
            chk($sformatf("%s_rd%0d", tag, k), rdata[k*XLEN +: XLEN],
                model_rd(int'(raddr[k*AW +: AW])));
        chk({tag, "_flag"}, 64'(err_flag), 64'(m_flag));
        chk({tag, "_cnt"},  64'(err_cnt),  64'(m_cnt));
        chk({tag, "_addr"}, 64'(err_addr), 64'(m_addr));
    endtask

    task automatic model_update();
        int q[$];
        if (regwrite && int'(waddr) >= HOT && !cold_en) q.push_back(int'(waddr));
        for (int k = 0; k < NRD; k++)
            if (int'(raddr[k*AW +: AW]) >= HOT && !cold_en) q.push_back(int'(raddr[k*AW +: AW]));
        if (q.size() > 0) begin
            if (clr || !m_flag) m_addr = q[0];
            m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            m_flag = 1'b1;
        end else if (clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
            m_addr = 0;
        end
        if (wr_accepted()) mem[waddr] = wdata;
    endtask

    // inputs change 1 time unit after posedge; checks happen at the negedge
    task automatic eval(input string tag);
        #4;
        model_check(tag);
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        eval(tag);
        adv();
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [63:0] wd,
                         input logic [AW-1:0] ra, input logic ce, input logic m, input logic cl);
        regwrite = we;
        waddr    = wa;
        wdata    = wd;
        raddr    = {NRD{ra}};
        cold_en  = ce;
        is16     = m;
        clr      = cl;
    endtask

    initial begin
        model_reset();
        drive(1'b0, 5'd0, 64'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        eval("reset");
        chk("reset_flag", 64'(err_flag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // hot write / read
        drive(1'b1, 5'd3, 64'h123456789ABCDEF0, 5'd3, 1'b0, 1'b0, 1'b0);
        step("hot_wr");
        drive(1'b0, 5'd0, 64'd0, 5'd3, 1'b0, 1'b0, 1'b0);
        eval("hot_rd");
        chk("hot_p0", rdata[63:0], 64'h123456789ABCDEF0);
        chk("hot_p1", rdata[127:64], 64'h123456789ABCDEF0);
        chk("hot_flag", 64'(err_flag), 64'd0);
        adv();

        // cold authorisation
        drive(1'b1, 5'd20, 64'hCAFEBABECAFEBABE, 5'd3, 1'b1, 1'b0, 1'b0);
        step("cold_wr");
        drive(1'b0, 5'd0, 64'd0, 5'd20, 1'b1, 1'b0, 1'b0);
        eval("cold_rd");
        chk("cold_rd_val", rdata[63:0], 64'hCAFEBABECAFEBABE);
        adv();
        drive(1'b1, 5'd20, 64'hDEADBEEFDEADBEEF, 5'd20, 1'b0, 1'b0, 1'b0);
        eval("cold_dis");
        chk("cold_dis_rd", rdata[63:0], 64'd0);
        adv();
        drive(1'b0, 5'd0, 64'd0, 5'd20, 1'b1, 1'b0, 1'b0);
        eval("cold_reen");
        chk("cold_reen_rd", rdata[63:0], 64'hCAFEBABECAFEBABE);
        chk("cold_err_flag", 64'(err_flag), 64'd1);
        chk("cold_err_addr", 64'(err_addr), 64'd20);
        chk("cold_err_cnt", 64'(err_cnt), 64'd1);
        adv();

        // x0 and 16-bit mode
        drive(1'b1, 5'd0, 64'hABABABABABABABAB, 5'd3, 1'b1, 1'b1, 1'b0);
        step("x0_wr16");
        drive(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        eval("x0_rd16");
        chk("x0_rd16_val", rdata[63:0], 64'hABABABABABABABAB);
        adv();
        drive(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        eval("x0_rdn");
        chk("x0_rdn_val", rdata[63:0], 64'd0);
        adv();
        drive(1'b1, 5'd0, 64'h1111111111111111, 5'd0, 1'b1, 1'b0, 1'b0);
        step("x0_wrn");
        drive(1'b0, 5'd0, 64'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        eval("x0_keep");
        chk("x0_keep_val", rdata[63:0], 64'hABABABABABABABAB);
        adv();

        // error log: clear, saturation, clear with simultaneous violation
        drive(1'b0, 5'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        step("clr");
        drive(1'b0, 5'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        eval("clr_after");
        chk("clr_cnt", 64'(err_cnt), 64'd0);
        chk("clr_flag", 64'(err_flag), 64'd0);
        adv();
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 5'd0, 64'd0, (i == 0) ? 5'd25 : AW'(16 + (i % 16)), 1'b0, 1'b0, 1'b0);
            step("sat");
        end
        drive(1'b0, 5'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        eval("sat_end");
        chk("sat_cnt", 64'(err_cnt), 64'hFF);
        chk("sat_addr", 64'(err_addr), 64'd25);
        adv();
        drive(1'b0, 5'd0, 64'd0, 5'd17, 1'b0, 1'b0, 1'b1);
        step("clr_viol");
        drive(1'b0, 5'd0, 64'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        eval("clr_viol_after");
        chk("clrv_cnt", 64'(err_cnt), 64'd1);
        chk("clrv_addr", 64'(err_addr), 64'd17);
        chk("clrv_flag", 64'(err_flag), 64'd1);
        adv();

        // same-cycle read/write conflict
        drive(1'b1, 5'd5, 64'hA1A2A3A4B1B2B3B4, 5'd3, 1'b1, 1'b0, 1'b0);
        step("rw_init");
        drive(1'b1, 5'd5, 64'hE1E2E3E4F1F2F3F4, 5'd5, 1'b1, 1'b0, 1'b0);
        eval("rw_same");
`ifdef RF_BYPASS_EN
        chk("rw_same_val", rdata[63:0], 64'hE1E2E3E4F1F2F3F4);
`else
        chk("rw_same_val", rdata[63:0], 64'hA1A2A3A4B1B2B3B4);
`endif
        adv();
        drive(1'b0, 5'd0, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        eval("rw_next");
        chk("rw_next_val", rdata[63:0], 64'hE1E2E3E4F1F2F3F4);
        adv();

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            regwrite = 1'($urandom_range(0, 1));
            waddr    = AW'($urandom);
            wdata    = {$urandom, $urandom};
            raddr    = (NRD*AW)'($urandom);
            cold_en  = ($urandom_range(0, 3) != 0);
            is16     = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        // reset asserted mid-write
        drive(1'b1, 5'd7, 64'h5555555555555555, 5'd3, 1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        raddr = {5'd5, 5'd20, 5'd0, 5'd3};
        #1;
        for (int k = 0; k < NRD; k++)
            chk($sformatf("rst_mid_rd%0d", k), rdata[k*XLEN +: XLEN], 64'd0);
        chk("rst_mid_flag", 64'(err_flag), 64'd0);
        chk("rst_mid_cnt", 64'(err_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        regwrite = 1'b0;
        rst_n = 1'b1;
        eval("post_rst");
        adv();
        drive(1'b1, 5'd7, 64'h0F0F0F0F0F0F0F0F, 5'd3, 1'b1, 1'b0, 1'b0);
        step("post_rst_wr");
        drive(1'b0, 5'd0, 64'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        eval("post_rst_rd");
        chk("post_rst_val", rdata[63:0], 64'h0F0F0F0F0F0F0F0F);
        adv();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
